// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: shadows done/pass/testnum registers from the write-back port
// and issues a registered pass/fail/timeout verdict. Optional macro: TEST_MON_WRCNT_EN.
module riscv_test_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DONE_REG       = 26,
  parameter int unsigned PASS_REG       = 27,
  parameter int unsigned TNUM_REG       = 3,
  parameter int unsigned DONE_VALUE     = 1,
  parameter int unsigned PASS_VALUE     = 1,
  parameter int unsigned SETTLE_CYCLES  = 10,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             mon_done,
  output logic             mon_pass,
  output logic             mon_fail,
  output logic             mon_timeout,
  output logic [XLEN-1:0]  fail_testnum,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SETTLE,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  state_t           state, state_n;
  logic [SET_W-1:0] settle_cnt, settle_n;
  logic [XLEN-1:0]  done_sh, pass_sh, tnum_sh;
  logic [XLEN-1:0]  tnum_merged;
  logic             live;
  logic             wr_hit;

  assign live   = (state == ST_RUN) || (state == ST_SETTLE);
  assign wr_hit = wb_en && (wb_addr != 5'd0);

  // Testnum as it will be after this edge, so a same-cycle write is captured.
  assign tnum_merged = (live && wr_hit && (wb_addr == 5'(TNUM_REG))) ? wb_data : tnum_sh;

  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    case (state)
      ST_RUN: begin
        if (done_sh == XLEN'(DONE_VALUE)) begin
          state_n  = ST_SETTLE;
          settle_n = SETTLE_LOAD;
        end else if ((TIMEOUT_CYCLES != 0) && (cycle_count == TIMEOUT_LAST)) begin
          state_n = ST_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          state_n = (pass_sh == XLEN'(PASS_VALUE)) ? ST_PASS : ST_FAIL;
        end else begin
          settle_n = settle_cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      settle_cnt   <= '0;
      done_sh      <= '0;
      pass_sh      <= '0;
      tnum_sh      <= '0;
      cycle_count  <= '0;
      mon_done     <= 1'b0;
      mon_pass     <= 1'b0;
      mon_fail     <= 1'b0;
      mon_timeout  <= 1'b0;
      fail_testnum <= '0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_n;
      if (live) begin
        if (wr_hit) begin
          if (wb_addr == 5'(DONE_REG)) done_sh <= wb_data;
          if (wb_addr == 5'(PASS_REG)) pass_sh <= wb_data;
          if (wb_addr == 5'(TNUM_REG)) tnum_sh <= wb_data;
        end
        // The verdict edge itself does not count, so the count freezes on entry.
        if ((state_n == ST_RUN || state_n == ST_SETTLE) && (cycle_count != '1)) begin
          cycle_count <= cycle_count + 1'b1;
        end
        case (state_n)
          ST_PASS: begin
            mon_done <= 1'b1;
            mon_pass <= 1'b1;
          end
          ST_FAIL: begin
            mon_done     <= 1'b1;
            mon_fail     <= 1'b1;
            fail_testnum <= tnum_merged;
          end
          ST_TIMEOUT: begin
            mon_done     <= 1'b1;
            mon_timeout  <= 1'b1;
            fail_testnum <= tnum_merged;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TEST_MON_WRCNT_EN
  logic [CNT_W-1:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
    end else if (live && wr_hit && (wr_cnt_q != '1)) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign wr_count = wr_cnt_q;
`else
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Randomized self-checking bench for riscv_test_monitor against a register-file reference model.
module tb_riscv_test_monitor;

  localparam int SETTLE = 10;
  localparam int TO     = 100;
  localparam int MAXC   = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        mon_done, mon_pass, mon_fail, mon_timeout;
  logic [31:0] fail_testnum, cycle_count, wr_count;

  logic        x_done, x_pass, x_fail, x_timeout;
  logic [31:0] x_tnum, x_cc, x_wrc;

  always #5 clk = ~clk;

  riscv_test_monitor #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .mon_done    (mon_done),
    .mon_pass    (mon_pass),
    .mon_fail    (mon_fail),
    .mon_timeout (mon_timeout),
    .fail_testnum(fail_testnum),
    .cycle_count (cycle_count),
    .wr_count    (wr_count)
  );

  // Done register mapped onto x0: must never see a done write.
  riscv_test_monitor #(
    .DONE_REG      (0),
    .TIMEOUT_CYCLES(0)
  ) u_x0 (
    .clk         (clk),
    .rst         (rst),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .mon_done    (x_done),
    .mon_pass    (x_pass),
    .mon_fail    (x_fail),
    .mon_timeout (x_timeout),
    .fail_testnum(x_tnum),
    .cycle_count (x_cc),
    .wr_count    (x_wrc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          pen  [MAXC+1];
  logic [4:0]  paddr[MAXC+1];
  logic [31:0] pdata[MAXC+1];

  int          exp_v;
  bit          exp_to, exp_pass;
  logic [31:0] exp_tnum;
  int          exp_wrc;

  task automatic clear_plan();
    for (int e = 0; e <= MAXC; e++) begin
      pen[e]   = 1'b0;
      paddr[e] = '0;
      pdata[e] = '0;
    end
  endtask

  task automatic add_wr(input int e, input logic [4:0] a, input logic [31:0] d);
    pen[e]   = 1'b1;
    paddr[e] = a;
    pdata[e] = d;
  endtask

  // Writes to registers the monitor does not watch (x0 included, often with value 1).
  task automatic add_noise(input int n, input int upto);
    logic [4:0] a;
    for (int i = 0; i < n; i++) begin
      a = 5'($urandom_range(0, 31));
      while (a == 5'd3 || a == 5'd26 || a == 5'd27) a = 5'($urandom_range(0, 31));
      add_wr($urandom_range(1, upto), a, (a == 5'd0) ? 32'd1 : $urandom);
    end
  endtask

  // Edge e is the e-th rising edge after reset release. Done is seen one edge after
  // its write; the verdict lands SETTLE edges after that; pass is read from the value
  // before the verdict edge, testnum includes a write on the verdict edge.
  task automatic compute_expected(input int ncyc);
    logic [31:0] rf[32];
    int settle_e;
    for (int r = 0; r < 32; r++) rf[r] = '0;
    settle_e = 0;
    exp_v = 0; exp_to = 0; exp_pass = 0; exp_tnum = '0; exp_wrc = 0;
    for (int e = 1; e <= ncyc; e++) begin
      if (exp_v == 0 && settle_e == 0) begin
        if (rf[26] == 32'd1) settle_e = e;
        else if (e == TO) begin exp_v = e; exp_to = 1; end
      end
      if (exp_v == 0 && settle_e != 0 && e == settle_e + SETTLE) begin
        exp_v    = e;
        exp_pass = (rf[27] == 32'd1);
      end
      if ((exp_v == 0 || exp_v == e) && pen[e] && paddr[e] != 5'd0) begin
        rf[paddr[e]] = pdata[e];
        exp_wrc++;
      end
      if (exp_v == e && (exp_to || !exp_pass)) exp_tnum = rf[3];
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (cycles) @(posedge clk);
    #1;
    n_checks++;
    if ({mon_done, mon_pass, mon_fail, mon_timeout} !== 4'b0 || fail_testnum !== '0 ||
        cycle_count !== '0 || wr_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got done=%b pass=%b fail=%b to=%b tnum=%0d cc=%0d wrc=%0d, want all 0",
               mon_done, mon_pass, mon_fail, mon_timeout, fail_testnum, cycle_count, wr_count);
    end
  endtask

  task automatic run_plan(input string name, input int ncyc);
    bit want_done;
    int exp_cc;
    int exp_wrc_out;
    compute_expected(ncyc);
    for (int e = 1; e <= ncyc; e++) begin
      @(negedge clk);
      rst = 1'b0; wb_en = pen[e]; wb_addr = paddr[e]; wb_data = pdata[e];
      @(posedge clk);
      #1;
      want_done = (exp_v != 0) && (e >= exp_v);
      n_checks++;
      if (mon_done !== want_done) begin
        n_fail++;
        $display("FAIL %s mon_done at edge %0d: got %b want %b", name, e, mon_done, want_done);
      end
      n_checks++;
      if (x_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s x0_done at edge %0d: got %b want 0", name, e, x_done);
      end
    end
    @(negedge clk);
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    exp_cc = (exp_v != 0) ? exp_v - 1 : ncyc;
`ifdef TEST_MON_WRCNT_EN
    exp_wrc_out = exp_wrc;
`else
    exp_wrc_out = 0;
`endif
    n_checks++;
    if (mon_pass !== (exp_v != 0 && !exp_to && exp_pass) ||
        mon_fail !== (exp_v != 0 && !exp_to && !exp_pass) ||
        mon_timeout !== (exp_v != 0 && exp_to)) begin
      n_fail++;
      $display("FAIL %s verdict: got pass=%b fail=%b to=%b want pass=%b fail=%b to=%b", name,
               mon_pass, mon_fail, mon_timeout, (exp_v != 0 && !exp_to && exp_pass),
               (exp_v != 0 && !exp_to && !exp_pass), (exp_v != 0 && exp_to));
    end
    n_checks++;
    if (fail_testnum !== exp_tnum) begin
      n_fail++;
      $display("FAIL %s fail_testnum: got %0d want %0d", name, fail_testnum, exp_tnum);
    end
    n_checks++;
    if (cycle_count !== 32'(exp_cc)) begin
      n_fail++;
      $display("FAIL %s cycle_count: got %0d want %0d", name, cycle_count, exp_cc);
    end
    n_checks++;
    if (wr_count !== 32'(exp_wrc_out)) begin
      n_fail++;
      $display("FAIL %s wr_count: got %0d want %0d", name, wr_count, exp_wrc_out);
    end
  endtask

  task automatic test_reset();
    do_reset(2);
  endtask

  task automatic test_pass();
    do_reset(2); clear_plan();
    add_noise(8, 60);
    add_wr(5, 5'd3, 32'd5); add_wr(10, 5'd27, 32'd1); add_wr(40, 5'd26, 32'd1);
    run_plan("pass", 60);
  endtask

  task automatic test_fail();
    do_reset(2); clear_plan();
    add_noise(8, 70);
    add_wr(3, 5'd3, 32'd7); add_wr(6, 5'd27, 32'd0);
    add_wr($urandom_range(20, 60), 5'd26, 32'd1);
    run_plan("fail", 80);
  endtask

  task automatic test_late_pass();
    do_reset(2); clear_plan();
    add_wr(2, 5'd3, 32'd9); add_wr(4, 5'd27, 32'd0);
    add_wr(30, 5'd26, 32'd1); add_wr(35, 5'd27, 32'd1);
    run_plan("late_pass", 50);
  endtask

  task automatic test_timeout();
    do_reset(2); clear_plan();
    add_noise(10, 110);
    add_wr(50, 5'd3, $urandom); add_wr(60, 5'd27, 32'd1);
    run_plan("timeout", 110);
  endtask

  task automatic test_done_timeout_same();
    do_reset(2); clear_plan();
    add_wr(10, 5'd27, 32'd1); add_wr(99, 5'd26, 32'd1);
    run_plan("done_vs_timeout", 120);
  endtask

  task automatic test_wrcount();
    do_reset(2); clear_plan();
    for (int i = 0; i < 10; i++) add_wr(2 + i, 5'(5 + i), $urandom);
    add_wr(12, 5'd0, 32'd1); add_wr(13, 5'd0, 32'd1);
    run_plan("wrcount", 20);
  endtask

  task automatic test_reset_mid_settle();
    do_reset(2); clear_plan();
    add_wr(5, 5'd27, 32'd0); add_wr(20, 5'd26, 32'd1);
    run_plan("pre_abort", 25);
    do_reset(1);
    clear_plan();
    add_wr(3, 5'd3, 32'd4); add_wr(7, 5'd27, 32'd1); add_wr(15, 5'd26, 32'd1);
    run_plan("after_abort", 35);
  endtask

  task automatic test_random();
    logic [4:0]  a;
    logic [31:0] d;
    for (int it = 0; it < 6; it++) begin
      do_reset(2); clear_plan();
      for (int i = 0; i < $urandom_range(5, 40); i++) begin
        case ($urandom_range(0, 4))
          0: a = 5'd0;
          1: a = 5'd3;
          2: a = 5'd26;
          3: a = 5'd27;
          default: a = 5'($urandom_range(0, 31));
        endcase
        case ($urandom_range(0, 2))
          0: d = 32'd0;
          1: d = 32'd1;
          default: d = $urandom;
        endcase
        add_wr($urandom_range(1, 120), a, d);
      end
      run_plan("random", 130);
    end
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    test_reset();
    test_pass();
    test_fail();
    test_late_pass();
    test_timeout();
    test_done_timeout_same();
    test_wrcount();
    test_reset_mid_settle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable end-of-test monitor for the riscv_soc regression flow.
- Snoops the core's register-file write-back port and keeps shadow copies of three configurable registers: done flag, pass flag and test number.
- On done, waits a settle window, then delivers a registered pass/fail/timeout verdict with the failing test number and the cycle count.
- Placed beside the core in the SoC or bench wrapper; it has no hierarchical references.

Parameters:
- XLEN, 32, register data width.
- DONE_REG, 26, index of the register whose write of DONE_VALUE ends the test.
- PASS_REG, 27, index of the register holding the pass flag.
- TNUM_REG, 3, index of the register holding the current test number.
- DONE_VALUE, 1, value that marks the test complete.
- PASS_VALUE, 1, value of PASS_REG that means pass.
- SETTLE_CYCLES, 10, cycles waited after done before sampling PASS_REG (at least 1).
- TIMEOUT_CYCLES, 500, watchdog limit in cycles; 0 disables the watchdog.
- CNT_W, 32, width of the cycle and write counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_en  in  1  register write strobe
- wb_addr  in  5  destination register index
- wb_data  in  XLEN  write data
- mon_done  out  1  verdict valid (sticky)
- mon_pass  out  1  test passed
- mon_fail  out  1  test failed (PASS_REG != PASS_VALUE)
- mon_timeout  out  1  watchdog expired before done
- fail_testnum  out  XLEN  TNUM_REG shadow captured at verdict
- cycle_count  out  CNT_W  cycles from reset release to verdict
- wr_count  out  CNT_W  committed non-x0 writes (optional feature)

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge. It clears all shadows, counters, state and outputs to 0, and the FSM enters RUN.
- A reset asserted mid-test or after a verdict aborts or clears the test unconditionally.
- Shadow update: on a cycle with wb_en=1 and wb_addr!=0, a matching shadow loads wb_data. Writes to x0 are ignored.
- Shadows keep updating in RUN and SETTLE and freeze once a verdict is reached.
- FSM states: RUN, SETTLE, PASS, FAIL, TIMEOUT.
- RUN:
  - cycle_count increments each cycle, saturating at all-ones.
  - If the done shadow equals DONE_VALUE (value as registered, i.e. the cycle after the write) -> SETTLE, and the settle counter loads SETTLE_CYCLES-1.
  - Else, if TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT.
  - When done and timeout occur in the same cycle, done wins.
- SETTLE:
  - The settle counter decrements each cycle and cycle_count keeps counting.
  - The watchdog is not evaluated.
  - At counter==0: go to PASS if the pass shadow equals PASS_VALUE, else FAIL. fail_testnum captures the TNUM_REG shadow, and the merged shadow value is used if a write lands in that same cycle.
  - If the done register is rewritten to another value during SETTLE, the FSM still completes; the verdict is not cancelled.
- PASS / FAIL / TIMEOUT are terminal until rst:
  - mon_done=1 in all three.
  - Exactly one of mon_pass, mon_fail, mon_timeout is 1.
  - cycle_count freezes.
- Timing:
  - Outputs are registered and change on the clock edge of the state entry.
  - Latency from the done write edge to mon_done is SETTLE_CYCLES+1 cycles.
- fail_testnum:
  - Captured in FAIL and also in TIMEOUT.
  - Holds 0 in PASS.

Optional Feature:
- Macro TEST_MON_WRCNT_EN.
- Defined: wr_count increments once per cycle with wb_en=1 and wb_addr!=0, from reset until a verdict, then freezes. It saturates at all-ones.
- Not defined: no counter logic is built and wr_count is tied to 0.

Test Plan:
- Pass path: write x3=5, x27=1, then x26=1 at cycle 40 -> mon_done and mon_pass =1 exactly 11 cycles later, mon_fail=0, fail_testnum=0, cycle_count=51±1 per the defined counting.
- Fail path: write x3=7, x27=0, then x26=1 -> mon_fail=1, fail_testnum=7, mon_pass=0.
- Late pass write inside the settle window: x26=1, then x27=1 five cycles later with SETTLE_CYCLES=10 -> mon_pass=1.
- Watchdog: TIMEOUT_CYCLES=100 and x26 never written -> mon_timeout=1 at cycle 100, cycle_count=99 frozen.
- Done and timeout in the same cycle -> SETTLE is entered, no timeout is flagged.
- x0 write of 1 with DONE_REG=0 override test -> no transition. Then with TEST_MON_WRCNT_EN, 12 writes including 2 to x0 -> wr_count=10.
- Reset mid-SETTLE: assert rst for 1 cycle -> all outputs 0, state RUN, and a subsequent pass sequence completes normally.
